// File: rtl/ex_stage.sv
// ex_stage: MIPS execute stage with single-cycle ALU ops, HI/LO moves and iterative mul/div.
// Define EX_DIV_EN to build the 32-step restoring divider; otherwise DIV/DIVU retire as single-cycle no-ops.
`ifndef REG_ADDR_WIDTH
`define REG_ADDR_WIDTH 5
`endif
`ifndef REG_DATA_WIDTH
`define REG_DATA_WIDTH 32
`endif
`ifndef ALUSEL_WIDTH
`define ALUSEL_WIDTH 3
`endif
`ifndef ALUOP_WIDTH
`define ALUOP_WIDTH 6
`endif

module ex_stage #(
  parameter int DATA_W   = 32,
  parameter int MD_CNT_W = 6
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         valid_in,
  input  logic [`REG_ADDR_WIDTH-1:0]   reg_wr_addr_in,
  input  logic                         reg_wr_en_in,
  input  logic [`REG_DATA_WIDTH-1:0]   reg_rd_data1_in,
  input  logic [`REG_DATA_WIDTH-1:0]   reg_rd_data2_in,
  input  logic [`ALUSEL_WIDTH-1:0]     alusel_in,
  input  logic [`ALUOP_WIDTH-1:0]      aluop_in,
  output logic                         stall_req,
  output logic                         valid_out,
  output logic [`REG_ADDR_WIDTH-1:0]   reg_wr_addr_out,
  output logic                         reg_wr_en_out,
  output logic [`REG_DATA_WIDTH-1:0]   reg_wr_data_out,
  output logic                         ovf_out
);
  localparam logic [`ALUSEL_WIDTH-1:0] AS_NOP = 0, AS_LOGIC = 1, AS_SHIFT = 2,
                                       AS_ARITH = 3, AS_MOVE = 4, AS_MD = 5;
  localparam logic [`ALUOP_WIDTH-1:0] OP_AND = 6'h24, OP_OR = 6'h25, OP_XOR = 6'h26, OP_NOR = 6'h27,
    OP_SLL = 6'h00, OP_SRL = 6'h02, OP_SRA = 6'h03,
    OP_ADD = 6'h20, OP_ADDU = 6'h21, OP_SUB = 6'h22, OP_SUBU = 6'h23, OP_SLT = 6'h2A, OP_SLTU = 6'h2B,
    OP_MFHI = 6'h10, OP_MTHI = 6'h11, OP_MFLO = 6'h12, OP_MTLO = 6'h13,
    OP_MULT = 6'h18, OP_MULTU = 6'h19, OP_DIV = 6'h1A, OP_DIVU = 6'h1B;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
`ifdef EX_DIV_EN
    S_DIV,
`endif
    S_DONE
  } state_t;

  state_t              state, state_nxt;
  logic [MD_CNT_W-1:0] cnt;
  logic [DATA_W-1:0]   hi, lo;
  logic [DATA_W-1:0]   acc_hi, acc_lo, opb;
  logic                neg_q;

  logic [DATA_W-1:0] a, b, a_mag, b_mag;
  logic              is_md, is_mul, is_div, md_sgn, start_mul, start_div, last;

  assign a      = reg_rd_data1_in;
  assign b      = reg_rd_data2_in;
  assign is_md  = (alusel_in == AS_MD);
  assign is_mul = is_md && (aluop_in == OP_MULT || aluop_in == OP_MULTU);
  assign is_div = is_md && (aluop_in == OP_DIV  || aluop_in == OP_DIVU);
  assign md_sgn = (aluop_in == OP_MULT) || (aluop_in == OP_DIV);
  assign a_mag  = (md_sgn && a[DATA_W-1]) ? -a : a;
  assign b_mag  = (md_sgn && b[DATA_W-1]) ? -b : b;
  assign start_mul = (state == S_IDLE) && valid_in && is_mul;
  assign last   = (cnt == MD_CNT_W'(DATA_W-1));

  // Shift-add multiplier step: {carry, acc_hi, acc_lo} shifted right once per cycle
  logic [DATA_W:0]     mul_sum;
  logic [DATA_W-1:0]   mul_hi_nx, mul_lo_nx;
  logic [2*DATA_W-1:0] prod_mag, prod_s;
  assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb} : '0);
  assign mul_hi_nx = mul_sum[DATA_W:1];
  assign mul_lo_nx = {mul_sum[0], acc_lo[DATA_W-1:1]};
  assign prod_mag  = {mul_hi_nx, mul_lo_nx};
  assign prod_s    = neg_q ? -prod_mag : prod_mag;

`ifdef EX_DIV_EN
  logic              neg_r, dz;
  logic [DATA_W:0]   rem_sh, diff;
  logic [DATA_W-1:0] rem_nx, quo_nx, rem_f, quo_f;
  assign start_div = (state == S_IDLE) && valid_in && is_div;
  assign rem_sh = {acc_hi, acc_lo[DATA_W-1]};
  assign diff   = rem_sh - {1'b0, opb};
  assign rem_nx = diff[DATA_W] ? rem_sh[DATA_W-1:0] : diff[DATA_W-1:0];
  assign quo_nx = {acc_lo[DATA_W-2:0], ~diff[DATA_W]};
  // A zero divisor leaves the dividend in the remainder, which the sign fix-up restores exactly
  assign rem_f  = neg_r ? -rem_nx : rem_nx;
  assign quo_f  = dz ? '1 : (neg_q ? -quo_nx : quo_nx);
`else
  assign start_div = 1'b0;
`endif

  assign stall_req = start_mul || start_div || (state == S_MUL)
`ifdef EX_DIV_EN
                     || (state == S_DIV)
`endif
                     ;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start_mul) state_nxt = S_MUL;
`ifdef EX_DIV_EN
              else if (start_div) state_nxt = S_DIV;
      S_DIV:  if (last) state_nxt = S_DONE;
`endif
      S_MUL:  if (last) state_nxt = S_DONE;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Single-cycle result
  logic [DATA_W-1:0] res, sum_add, sum_sub;
  logic              res_en, ovf, wr_hi, wr_lo;
  assign sum_add = a + b;
  assign sum_sub = a - b;

  always_comb begin
    res    = '0;
    res_en = reg_wr_en_in;
    ovf    = 1'b0;
    wr_hi  = 1'b0;
    wr_lo  = 1'b0;
    case (alusel_in)
      AS_LOGIC: case (aluop_in)
        OP_AND: res = a & b;
        OP_OR:  res = a | b;
        OP_XOR: res = a ^ b;
        OP_NOR: res = ~(a | b);
        default: res = '0;
      endcase
      AS_SHIFT: case (aluop_in)
        OP_SLL: res = b << a[4:0];
        OP_SRL: res = b >> a[4:0];
        OP_SRA: res = $signed(b) >>> a[4:0];
        default: res = '0;
      endcase
      AS_ARITH: case (aluop_in)
        OP_ADD: begin
          res = sum_add;
          ovf = (a[DATA_W-1] == b[DATA_W-1]) && (sum_add[DATA_W-1] != a[DATA_W-1]);
        end
        OP_ADDU: res = sum_add;
        OP_SUB: begin
          res = sum_sub;
          ovf = (a[DATA_W-1] != b[DATA_W-1]) && (sum_sub[DATA_W-1] != a[DATA_W-1]);
        end
        OP_SUBU: res = sum_sub;
        OP_SLT:  res = {{(DATA_W-1){1'b0}}, $signed(a) < $signed(b)};
        OP_SLTU: res = {{(DATA_W-1){1'b0}}, a < b};
        default: res = '0;
      endcase
      AS_MOVE: case (aluop_in)
        OP_MFHI: res = hi;
        OP_MFLO: res = lo;
        OP_MTHI: begin wr_hi = 1'b1; res_en = 1'b0; end
        OP_MTLO: begin wr_lo = 1'b1; res_en = 1'b0; end
        default: res = '0;
      endcase
      AS_MD: if (is_mul || is_div) res_en = 1'b0;
      default: res = '0;
    endcase
    if (ovf) res_en = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_out <= 1'b0; reg_wr_addr_out <= '0; reg_wr_en_out <= 1'b0;
      reg_wr_data_out <= '0; ovf_out <= 1'b0;
      hi <= '0; lo <= '0; cnt <= '0;
      acc_hi <= '0; acc_lo <= '0; opb <= '0; neg_q <= 1'b0;
`ifdef EX_DIV_EN
      neg_r <= 1'b0; dz <= 1'b0;
`endif
    end else begin
      valid_out <= 1'b0; reg_wr_addr_out <= '0; reg_wr_en_out <= 1'b0;
      reg_wr_data_out <= '0; ovf_out <= 1'b0;
      case (state)
        S_IDLE: if (start_mul || start_div) begin
          acc_hi <= '0;
          acc_lo <= a_mag;
          opb    <= b_mag;
          neg_q  <= md_sgn && (a[DATA_W-1] ^ b[DATA_W-1]);
          cnt    <= '0;
`ifdef EX_DIV_EN
          neg_r  <= md_sgn && a[DATA_W-1];
          dz     <= (b == '0);
`endif
        end else if (valid_in) begin
          valid_out       <= 1'b1;
          reg_wr_addr_out <= reg_wr_addr_in;
          reg_wr_en_out   <= res_en;
          reg_wr_data_out <= res;
          ovf_out         <= ovf;
          if (wr_hi) hi <= a;
          if (wr_lo) lo <= a;
        end
        S_MUL: begin
          acc_hi <= mul_hi_nx;
          acc_lo <= mul_lo_nx;
          cnt    <= cnt + 1'b1;
          if (last) begin
            {hi, lo}  <= prod_s;
            valid_out <= 1'b1;
          end
        end
`ifdef EX_DIV_EN
        S_DIV: begin
          acc_hi <= rem_nx;
          acc_lo <= quo_nx;
          cnt    <= cnt + 1'b1;
          if (last) begin
            hi <= rem_f;
            lo <= quo_f;
            valid_out <= 1'b1;
          end
        end
`endif
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: table-driven single-cycle vectors through a scoreboard queue,
// plus hand sequences for mul/div, HI/LO moves and reset during an iteration.
module tb_ex_stage;
  logic        clk = 1'b0, rst = 1'b1;
  logic        valid_in = 1'b0, reg_wr_en_in = 1'b0;
  logic [4:0]  reg_wr_addr_in = '0;
  logic [31:0] reg_rd_data1_in = '0, reg_rd_data2_in = '0;
  logic [2:0]  alusel_in = '0;
  logic [5:0]  aluop_in = '0;
  logic        stall_req, valid_out, reg_wr_en_out, ovf_out;
  logic [4:0]  reg_wr_addr_out;
  logic [31:0] reg_wr_data_out;

  ex_stage dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .reg_wr_addr_in(reg_wr_addr_in),
    .reg_wr_en_in(reg_wr_en_in), .reg_rd_data1_in(reg_rd_data1_in), .reg_rd_data2_in(reg_rd_data2_in),
    .alusel_in(alusel_in), .aluop_in(aluop_in), .stall_req(stall_req), .valid_out(valid_out),
    .reg_wr_addr_out(reg_wr_addr_out), .reg_wr_en_out(reg_wr_en_out),
    .reg_wr_data_out(reg_wr_data_out), .ovf_out(ovf_out));

  always #5 clk = ~clk;

  localparam logic [2:0] NOP = 0, LOG = 1, SHF = 2, ARI = 3, MOV = 4, MD = 5;

  typedef struct {
    logic valid; logic [4:0] addr; logic en; logic [31:0] data; logic ovf; logic chk_data;
  } exp_t;
  typedef struct {
    logic [2:0] sel; logic [5:0] op; logic [31:0] a, b; logic [4:0] addr; logic en_in, vin; exp_t e;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[$];
  int checks = 0, failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [2:0] sel, input logic [5:0] op, input logic [31:0] a, b,
                              input logic [4:0] addr, input logic en_in, vin, ev, een,
                              input logic [31:0] ed, input logic eovf, cd);
    vec_t v;
    v.sel = sel; v.op = op; v.a = a; v.b = b; v.addr = addr; v.en_in = en_in; v.vin = vin;
    v.e.valid = ev; v.e.addr = ev ? addr : 5'd0; v.e.en = een; v.e.data = ed; v.e.ovf = eovf;
    v.e.chk_data = cd;
    return v;
  endfunction

  task automatic drive(input logic [2:0] sel, input logic [5:0] op, input logic [31:0] a, b,
                       input logic [4:0] addr, input logic en_in, vin);
    alusel_in = sel; aluop_in = op; reg_rd_data1_in = a; reg_rd_data2_in = b;
    reg_wr_addr_in = addr; reg_wr_en_in = en_in; valid_in = vin;
  endtask

  // Drive one instruction, queue its expectation, compare the registered result one edge later
  task automatic step(input vec_t v, input string name);
    exp_t e;
    drive(v.sel, v.op, v.a, v.b, v.addr, v.en_in, v.vin);
    sb.push_back(v.e);
    @(posedge clk); #1;
    if (sb.size() == 0) begin
      chk({name, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk({name, "_valid"}, {31'd0, valid_out}, {31'd0, e.valid});
      chk({name, "_addr"}, {27'd0, reg_wr_addr_out}, {27'd0, e.addr});
      chk({name, "_en"}, {31'd0, reg_wr_en_out}, {31'd0, e.en});
      chk({name, "_ovf"}, {31'd0, ovf_out}, {31'd0, e.ovf});
      if (e.chk_data) chk({name, "_data"}, reg_wr_data_out, e.data);
    end
  endtask

  task automatic read_hilo(input logic [31:0] hi, lo, input string name);
    step(mk(MOV, 6'h10, 0, 0, 5'd9, 1, 1, 1, 1, hi, 0, 1), {name, "_mfhi"});
    step(mk(MOV, 6'h12, 0, 0, 5'd10, 1, 1, 1, 1, lo, 0, 1), {name, "_mflo"});
  endtask

  task automatic md_run(input logic [5:0] op, input logic [31:0] a, b, hi, lo,
                        input logic multi, input string name);
    int n;
    drive(MD, op, a, b, 5'd4, 1'b1, 1'b1);
    #1;
    n = 0;
    while (stall_req === 1'b1 && n < 100) begin
      n++;
      @(posedge clk); #1;
    end
    if (multi) chk({name, "_stall_cycles"}, n, 33);
    else begin
      chk({name, "_stall_cycles"}, n, 0);
      @(posedge clk); #1;
    end
    chk({name, "_done_valid"}, {31'd0, valid_out}, 32'd1);
    chk({name, "_done_en"}, {31'd0, reg_wr_en_out}, 32'd0);
    if (multi) begin
      chk({name, "_done_stall"}, {31'd0, stall_req}, 32'd0);
      @(posedge clk); #1;
      chk({name, "_dup_valid"}, {31'd0, valid_out}, 32'd0);
    end
    read_hilo(hi, lo, name);
  endtask

`ifdef EX_DIV_EN
  localparam logic DIV_MC = 1'b1;
`else
  localparam logic DIV_MC = 1'b0;
`endif

  initial begin
    logic [31:0] div_hi, div_lo;
    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", {31'd0, valid_out}, 0);
    chk("rst_en", {31'd0, reg_wr_en_out}, 0);
    chk("rst_data", reg_wr_data_out, 0);
    chk("rst_ovf", {31'd0, ovf_out}, 0);
    chk("rst_stall", {31'd0, stall_req}, 0);
    rst = 1'b0;

    vecs.push_back(mk(ARI, 6'h20, 32'h7FFFFFFF, 32'h1, 5'd1, 1, 1, 1, 0, 32'h80000000, 1, 1));
    vecs.push_back(mk(ARI, 6'h21, 32'h7FFFFFFF, 32'h1, 5'd2, 1, 1, 1, 1, 32'h80000000, 0, 1));
    vecs.push_back(mk(SHF, 6'h03, 32'd4, 32'hF0000000, 5'd3, 1, 1, 1, 1, 32'hFF000000, 0, 1));
    vecs.push_back(mk(ARI, 6'h2B, 32'd1, 32'hFFFFFFFF, 5'd4, 1, 1, 1, 1, 32'd1, 0, 1));
    vecs.push_back(mk(ARI, 6'h2A, 32'hFFFFFFFF, 32'd1, 5'd5, 1, 1, 1, 1, 32'd1, 0, 1));
    vecs.push_back(mk(LOG, 6'h24, 32'hF0F0F0F0, 32'hFF00FF00, 5'd6, 1, 1, 1, 1, 32'hF000F000, 0, 1));
    vecs.push_back(mk(LOG, 6'h25, 32'hF0F0F0F0, 32'hFF00FF00, 5'd7, 1, 1, 1, 1, 32'hFFF0FFF0, 0, 1));
    vecs.push_back(mk(LOG, 6'h26, 32'hF0F0F0F0, 32'hFF00FF00, 5'd8, 1, 1, 1, 1, 32'h0FF00FF0, 0, 1));
    vecs.push_back(mk(LOG, 6'h27, 32'hF0F0F0F0, 32'hFF00FF00, 5'd9, 1, 1, 1, 1, 32'h000F000F, 0, 1));
    vecs.push_back(mk(SHF, 6'h00, 32'd8, 32'h12345678, 5'd10, 1, 1, 1, 1, 32'h34567800, 0, 1));
    vecs.push_back(mk(SHF, 6'h02, 32'd4, 32'hF0000000, 5'd11, 1, 1, 1, 1, 32'h0F000000, 0, 1));
    vecs.push_back(mk(ARI, 6'h22, 32'h80000000, 32'd1, 5'd12, 1, 1, 1, 0, 32'h7FFFFFFF, 1, 1));
    vecs.push_back(mk(ARI, 6'h23, 32'd5, 32'd7, 5'd13, 1, 1, 1, 1, 32'hFFFFFFFE, 0, 1));
    vecs.push_back(mk(ARI, 6'h20, 32'd5, 32'hFFFFFFFD, 5'd14, 1, 1, 1, 1, 32'd2, 0, 1));
    vecs.push_back(mk(ARI, 6'h22, 32'hFFFFFFFE, 32'd3, 5'd15, 1, 1, 1, 1, 32'hFFFFFFFB, 0, 1));
    vecs.push_back(mk(NOP, 6'h00, 32'd5, 32'd6, 5'd16, 1, 1, 1, 1, 32'd0, 0, 1));
    vecs.push_back(mk(LOG, 6'h30, 32'd5, 32'd6, 5'd17, 1, 1, 1, 1, 32'd0, 0, 1));
    vecs.push_back(mk(ARI, 6'h21, 32'd5, 32'd6, 5'd18, 1, 0, 0, 0, 32'd0, 0, 1));
    foreach (vecs[i]) step(vecs[i], $sformatf("vec%0d", i));

    md_run(6'h18, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFA, 1'b1, "mult");

    div_hi = DIV_MC ? 32'hFFFFFFFF : 32'hFFFFFFFF;
    div_lo = DIV_MC ? 32'hFFFFFFFD : 32'hFFFFFFFA;
    md_run(6'h1A, 32'hFFFFFFF9, 32'd2, div_hi, div_lo, DIV_MC, "div_neg");
    div_hi = DIV_MC ? 32'd10 : 32'hFFFFFFFF;
    div_lo = DIV_MC ? 32'hFFFFFFFF : 32'hFFFFFFFA;
    md_run(6'h1B, 32'd10, 32'd0, div_hi, div_lo, DIV_MC, "divu_zero");
`ifdef EX_DIV_EN
    md_run(6'h1A, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 1'b1, "div_minint");
`endif

    // MTHI then MFHI back-to-back; MTLO then MFLO
    step(mk(MOV, 6'h11, 32'h1234, 0, 5'd20, 1, 1, 1, 0, 32'd0, 0, 0), "mthi");
    step(mk(MOV, 6'h10, 0, 0, 5'd21, 1, 1, 1, 1, 32'h1234, 0, 1), "mfhi_fwd");
    step(mk(MOV, 6'h13, 32'h55, 0, 5'd22, 1, 1, 1, 0, 32'd0, 0, 0), "mtlo");
    step(mk(MOV, 6'h12, 0, 0, 5'd23, 1, 1, 1, 1, 32'h55, 0, 1), "mflo_fwd");

    // reset in the middle of MULTU
    drive(MD, 6'h19, 32'd3, 32'd5, 5'd4, 1'b1, 1'b1);
    @(posedge clk); #1;
    repeat (10) @(posedge clk);
    #1;
    chk("mid_stall", {31'd0, stall_req}, 1);
    rst = 1'b1; valid_in = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_valid", {31'd0, valid_out}, 0);
    chk("abort_en", {31'd0, reg_wr_en_out}, 0);
    chk("abort_data", reg_wr_data_out, 0);
    chk("abort_ovf", {31'd0, ovf_out}, 0);
    chk("abort_stall", {31'd0, stall_req}, 0);
    read_hilo(32'd0, 32'd0, "abort");
    step(mk(ARI, 6'h21, 32'd1, 32'd1, 5'd25, 1, 1, 1, 1, 32'd2, 0, 1), "post_rst_addu");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
